draw_background_scroll: RTL and testbench

Parametrised successor of the static background renderer in the VGA pipeline. It draws sky, grass, a two-lane road and the cockpit in game mode, and a menu panel in menu mode. The road midline is dashed and scrolls horizontally at a speed input, updated once per frame, which gives the motion effect. It also accumulates per-frame travelled distance for the race logic downstream.

---
 rtl/draw_background_scroll_if.sv | 13 +
 rtl/draw_background_scroll.sv | 228 ++++++++++++++++++++++
 tb/tb_draw_background_scroll.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_background_scroll_if.sv
// VGA timing bundle (counters, syncs, blanking) passed between pipeline stages.
// The master drives the bundle; the slave consumes it.
interface draw_background_scroll_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_background_scroll.sv
// Background renderer with a horizontally scrolling dashed road midline.
// Two-stage pipeline: stage 1 classifies the pixel, stage 2 turns it into a colour.
module draw_background_scroll #(
  parameter int SPEED_W     = 8,
  parameter int PERIOD_LOG2 = 7,
  parameter int DASH_LEN    = 64,
  parameter int SKY_END     = 169,
  parameter int ROAD_TOP    = 269,
  parameter int ROAD_BOT    = 646,
  parameter int SIDE_W      = 6,
  parameter int MID_TOP     = 455,
  parameter int MID_BOT     = 460,
  parameter int COCK_L      = 311,
  parameter int COCK_R      = 711,
  parameter int RECT_X      = 242,
  parameter int RECT_Y      = 119,
  parameter int RECT_W      = 540,
  parameter int RECT_H      = 530,
  parameter int DIST_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  draw_background_scroll_if.slave  in_if,
  draw_background_scroll_if.master out_if,
  input  logic                     mode_in,
  input  logic [SPEED_W-1:0]       speed_in,
  output logic [11:0]              rgb_out,
  output logic [PERIOD_LOG2-1:0]   offset_out,
  output logic [DIST_W-1:0]        distance_out
);

  localparam logic [11:0] COL_SKY        = 12'h5CF;
  localparam logic [11:0] COL_GRASS      = 12'h494;
  localparam logic [11:0] COL_ROAD       = 12'h9AB;
  localparam logic [11:0] COL_MID        = 12'hFF4;
  localparam logic [11:0] COL_SIDE       = 12'h466;
  localparam logic [11:0] COL_COCKPIT    = 12'h111;
  localparam logic [11:0] COL_PANEL      = 12'hF52;
  localparam logic [11:0] COL_PANEL_EDGE = 12'h000;

  localparam logic [10:0] SKY_END_C   = 11'(SKY_END);
  localparam logic [10:0] ROAD_TOP_C  = 11'(ROAD_TOP);
  localparam logic [10:0] SIDE_TOP_C  = 11'(ROAD_TOP + SIDE_W);
  localparam logic [10:0] ROAD_IN_C   = 11'(ROAD_BOT - SIDE_W);
  localparam logic [10:0] ROAD_BOT_C  = 11'(ROAD_BOT);
  localparam logic [10:0] MID_TOP_C   = 11'(MID_TOP);
  localparam logic [10:0] MID_BOT_C   = 11'(MID_BOT);
  localparam logic [10:0] COCK_L_C    = 11'(COCK_L);
  localparam logic [10:0] COCK_R_C    = 11'(COCK_R);
  localparam logic [10:0] RECT_X0_C   = 11'(RECT_X);
  localparam logic [10:0] RECT_X1_C   = 11'(RECT_X + RECT_W - 1);
  localparam logic [10:0] RECT_Y0_C   = 11'(RECT_Y);
  localparam logic [10:0] RECT_Y1_C   = 11'(RECT_Y + RECT_H - 1);
  localparam logic [10:0] INNER_X0_C  = 11'(RECT_X + 2);
  localparam logic [10:0] INNER_X1_C  = 11'(RECT_X + RECT_W - 3);
  localparam logic [10:0] INNER_Y0_C  = 11'(RECT_Y + 2);
  localparam logic [10:0] INNER_Y1_C  = 11'(RECT_Y + RECT_H - 3);

  localparam logic [PERIOD_LOG2-1:0] DASH_LEN_C = PERIOD_LOG2'(DASH_LEN);
  localparam logic [31:0]            SPD_MAX_C  = 32'(2**PERIOD_LOG2 - 1);

  typedef enum logic [3:0] {
    R_BLANK,
    R_SKY,
    R_GRASS,
    R_SIDE,
    R_MIDLINE,
    R_ROAD,
    R_COCKPIT,
    R_PANEL,
    R_EDGE
  } region_t;

  // Per-frame state
  logic                   mode_l_reg;
  logic                   armed_reg;
  logic [PERIOD_LOG2-1:0] offset_reg;
  logic [DIST_W-1:0]      distance_reg;

  // Stage 1
  logic [10:0]            hcount_s1_reg;
  logic [10:0]            vcount_s1_reg;
  logic                   hsync_s1_reg;
  logic                   vsync_s1_reg;
  logic                   hblnk_s1_reg;
  logic                   vblnk_s1_reg;
  region_t                region_s1_reg;
  logic                   dash_s1_reg;

  region_t                region_next;
  logic                   dash_next;
  logic [PERIOD_LOG2-1:0] dash_pos;
  logic [11:0]            rgb_next;

  logic                   frame_tick;
  logic [PERIOD_LOG2-1:0] spd;
  logic [DIST_W:0]        dist_sum;
  logic [DIST_W-1:0]      dist_next;

  // armed_reg blocks a spurious tick when vblnk is already high as reset releases.
  assign frame_tick = in_if.vblnk & ~vblnk_s1_reg & armed_reg;
  assign spd        = (32'(speed_in) > SPD_MAX_C) ? '1 : PERIOD_LOG2'(speed_in);
  assign dist_sum   = {1'b0, distance_reg} + (DIST_W+1)'(spd);
  assign dist_next  = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_l_reg   <= 1'b0;
      armed_reg    <= 1'b0;
      offset_reg   <= '0;
      distance_reg <= '0;
    end else begin
      if (!in_if.vblnk)
        armed_reg <= 1'b1;
      if (frame_tick) begin
        mode_l_reg <= mode_in;
        if (mode_in) begin
          offset_reg   <= offset_reg + spd;
          distance_reg <= dist_next;
        end else begin
          distance_reg <= '0;
        end
      end
    end
  end

  assign offset_out   = offset_reg;
  assign distance_out = distance_reg;

  // The low counter bits plus the offset wrap naturally modulo the dash period.
  assign dash_pos  = in_if.hcount[PERIOD_LOG2-1:0] + offset_reg;
  assign dash_next = (dash_pos < DASH_LEN_C);

  always_comb begin
    region_next = R_BLANK;
    if (in_if.hblnk || in_if.vblnk) begin
      region_next = R_BLANK;
    end else if (mode_l_reg) begin
      if (in_if.vcount <= SKY_END_C)
        region_next = R_SKY;
      else if (in_if.vcount < ROAD_TOP_C)
        region_next = R_GRASS;
      else if (in_if.vcount < SIDE_TOP_C)
        region_next = R_SIDE;
      else if (in_if.vcount >= MID_TOP_C && in_if.vcount <= MID_BOT_C)
        region_next = R_MIDLINE;
      else if (in_if.vcount <= ROAD_IN_C)
        region_next = R_ROAD;
      else if (in_if.vcount <= ROAD_BOT_C)
        region_next = R_SIDE;
      else if (in_if.hcount >= COCK_L_C && in_if.hcount <= COCK_R_C)
        region_next = R_COCKPIT;
      else
        region_next = R_GRASS;
    end else begin
      if (in_if.hcount >= RECT_X0_C && in_if.hcount <= RECT_X1_C &&
          in_if.vcount >= RECT_Y0_C && in_if.vcount <= RECT_Y1_C) begin
        if (in_if.hcount < INNER_X0_C || in_if.hcount > INNER_X1_C ||
            in_if.vcount < INNER_Y0_C || in_if.vcount > INNER_Y1_C)
          region_next = R_EDGE;
        else
          region_next = R_PANEL;
      end else if (in_if.vcount <= SKY_END_C) begin
        region_next = R_SKY;
      end else begin
        region_next = R_GRASS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s1_reg <= '0;
      vcount_s1_reg <= '0;
      hsync_s1_reg  <= 1'b0;
      vsync_s1_reg  <= 1'b0;
      hblnk_s1_reg  <= 1'b0;
      vblnk_s1_reg  <= 1'b0;
      region_s1_reg <= R_BLANK;
      dash_s1_reg   <= 1'b0;
    end else begin
      hcount_s1_reg <= in_if.hcount;
      vcount_s1_reg <= in_if.vcount;
      hsync_s1_reg  <= in_if.hsync;
      vsync_s1_reg  <= in_if.vsync;
      hblnk_s1_reg  <= in_if.hblnk;
      vblnk_s1_reg  <= in_if.vblnk;
      region_s1_reg <= region_next;
      dash_s1_reg   <= dash_next;
    end
  end

  always_comb begin
    rgb_next = 12'h000;
    case (region_s1_reg)
      R_SKY:     rgb_next = COL_SKY;
      R_GRASS:   rgb_next = COL_GRASS;
      R_SIDE:    rgb_next = COL_SIDE;
      R_MIDLINE: rgb_next = dash_s1_reg ? COL_MID : COL_ROAD;
      R_ROAD:    rgb_next = COL_ROAD;
      R_COCKPIT: rgb_next = COL_COCKPIT;
      R_PANEL:   rgb_next = COL_PANEL;
      R_EDGE:    rgb_next = COL_PANEL_EDGE;
      default:   rgb_next = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_if.hcount <= '0;
      out_if.vcount <= '0;
      out_if.hsync  <= 1'b0;
      out_if.vsync  <= 1'b0;
      out_if.hblnk  <= 1'b0;
      out_if.vblnk  <= 1'b0;
      rgb_out       <= 12'h000;
    end else begin
      out_if.hcount <= hcount_s1_reg;
      out_if.vcount <= vcount_s1_reg;
      out_if.hsync  <= hsync_s1_reg;
      out_if.vsync  <= vsync_s1_reg;
      out_if.hblnk  <= hblnk_s1_reg;
      out_if.vblnk  <= vblnk_s1_reg;
      rgb_out       <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_background_scroll.sv
// Directed and randomized checks of draw_background_scroll against a pixel-rule
// reference model (colour per region, per-frame offset/distance arithmetic).
module tb_draw_background_scroll;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_in;
  logic [7:0]  speed_in;
  logic [11:0] rgb_out;
  logic [6:0]  offset_out;
  logic [15:0] distance_out;

  draw_background_scroll_if in_if ();
  draw_background_scroll_if out_if ();

  draw_background_scroll dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (in_if),
    .out_if       (out_if),
    .mode_in      (mode_in),
    .speed_in     (speed_in),
    .rgb_out      (rgb_out),
    .offset_out   (offset_out),
    .distance_out (distance_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: latched mode, scroll offset, distance, tick arming.
  int m_mode   = 0;
  int m_offset = 0;
  int m_dist   = 0;
  bit m_armed  = 1'b0;
  bit last_vb  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_rgb(input int mode, input int h, input int v,
                                 input bit hb, input bit vb, input int off);
    if (hb || vb) return 'h000;
    if (mode != 0) begin
      if (v <= 169) return 'h5CF;
      if (v < 269) return 'h494;
      if (v < 275) return 'h466;
      if (v >= 455 && v <= 460) return (((h + off) % 128) < 64) ? 'hFF4 : 'h9AB;
      if (v <= 640) return 'h9AB;
      if (v <= 646) return 'h466;
      if (h >= 311 && h <= 711) return 'h111;
      return 'h494;
    end
    if (h >= 242 && h <= 781 && v >= 119 && v <= 648) begin
      if (h < 244 || h > 779 || v < 121 || v > 646) return 'h000;
      return 'hF52;
    end
    return (v <= 169) ? 'h5CF : 'h494;
  endfunction

  task automatic model_tick();
    int spd;
    spd = (int'(speed_in) > 127) ? 127 : int'(speed_in);
    m_mode = int'(mode_in);
    if (m_mode != 0) begin
      m_offset = (m_offset + spd) % 128;
      m_dist   = (m_dist + spd > 65535) ? 65535 : m_dist + spd;
    end else begin
      m_dist = 0;
    end
  endtask

  // One clock edge; the model decides whether this edge is a frame tick.
  task automatic step();
    bit tick;
    tick = !rst && in_if.vblnk && !last_vb && m_armed;
    if (rst) begin
      m_mode = 0; m_offset = 0; m_dist = 0; m_armed = 1'b0; last_vb = 1'b0;
    end else begin
      if (!in_if.vblnk) m_armed = 1'b1;
      last_vb = in_if.vblnk;
    end
    if (tick) model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb);
    logic [10:0] hv, vv;
    hv = 11'(h);
    vv = 11'(v);
    in_if.hcount = hv;
    in_if.vcount = vv;
    in_if.hsync  = hv[3];
    in_if.vsync  = vv[2];
    in_if.hblnk  = hb;
    in_if.vblnk  = vb;
  endtask

  task automatic px(input string tag, input int h, input int v, input bit hb, input bit vb);
    int exp;
    logic [10:0] hv, vv;
    hv = 11'(h);
    vv = 11'(v);
    exp = exp_rgb(m_mode, h, v, hb, vb, m_offset);
    drive(h, v, hb, vb);
    step();
    step();
    check({tag, ".rgb"}, 32'(rgb_out), 32'(exp));
    check({tag, ".hcount"}, 32'(out_if.hcount), 32'(hv));
    check({tag, ".vcount"}, 32'(out_if.vcount), 32'(vv));
    check({tag, ".sync"}, 32'({out_if.hsync, out_if.vsync}), 32'({hv[3], vv[2]}));
    check({tag, ".blnk"}, 32'({out_if.hblnk, out_if.vblnk}), 32'({hb, vb}));
    $display("px %s h=%0d v=%0d hb=%0d vb=%0d rgb=%03h", tag, h, v, hb, vb, rgb_out);
  endtask

  task automatic frame_tick(input string tag);
    drive(0, 600, 1'b1, 1'b0);
    step();
    drive(0, 600, 1'b1, 1'b1);
    step();
    check({tag, ".offset"}, 32'(offset_out), 32'(m_offset));
    check({tag, ".distance"}, 32'(distance_out), 32'(m_dist));
    $display("tick %s mode=%0d speed=%0d offset=%0d distance=%0d",
             tag, mode_in, speed_in, offset_out, distance_out);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst      = 1'b1;
    mode_in  = 1'b0;
    speed_in = 8'd0;
    drive(0, 0, 1'b1, 1'b0);
    step();
    step();
    check("reset.rgb", 32'(rgb_out), 32'h000);
    check("reset.offset", 32'(offset_out), 32'd0);
    check("reset.distance", 32'(distance_out), 32'd0);
    check("reset.timing", 32'({out_if.hcount, out_if.vcount, out_if.hblnk}), 32'd0);
    rst = 1'b0;
    step();

    // Latency: nothing new after 1 clk, the new pixel after exactly 2
    drive(100, 50, 1'b0, 1'b0);
    step();
    check("lat1.rgb", 32'(rgb_out), 32'h000);
    check("lat1.hcount", 32'(out_if.hcount), 32'd0);
    step();
    check("lat2.rgb", 32'(rgb_out), 32'h5CF);
    check("lat2.hcount", 32'(out_if.hcount), 32'd100);
    check("lat2.vcount", 32'(out_if.vcount), 32'd50);
    $display("latency rgb=%03h", rgb_out);

    // Game mode, speed 0
    mode_in = 1'b1;
    speed_in = 8'd0;
    frame_tick("game.s0");
    px("dash.63", 63, 457, 1'b0, 1'b0);
    px("dash.64", 64, 457, 1'b0, 1'b0);
    px("dash.128", 128, 457, 1'b0, 1'b0);
    px("dash.hblnk", 63, 457, 1'b1, 1'b0);

    // Speed 10, three frames
    speed_in = 8'd10;
    for (int i = 0; i < 3; i++) frame_tick($sformatf("s10.%0d", i));
    check("s10.offset30", 32'(offset_out), 32'd30);
    check("s10.dist30", 32'(distance_out), 32'd30);
    px("s10.h33", 33, 457, 1'b0, 1'b0);
    px("s10.h34", 34, 457, 1'b0, 1'b0);
    px("s10.h97", 97, 457, 1'b0, 1'b0);
    px("s10.h98", 98, 457, 1'b0, 1'b0);

    // Game region boundaries
    px("g.sky", 100, 169, 1'b0, 1'b0);
    px("g.grass", 100, 170, 1'b0, 1'b0);
    px("g.grass268", 100, 268, 1'b0, 1'b0);
    px("g.side269", 100, 269, 1'b0, 1'b0);
    px("g.side274", 100, 274, 1'b0, 1'b0);
    px("g.road275", 100, 275, 1'b0, 1'b0);
    px("g.road640", 100, 640, 1'b0, 1'b0);
    px("g.side641", 100, 641, 1'b0, 1'b0);
    px("g.side646", 100, 646, 1'b0, 1'b0);
    px("g.cock311", 311, 647, 1'b0, 1'b0);
    px("g.cock711", 711, 700, 1'b0, 1'b0);
    px("g.grass310", 310, 700, 1'b0, 1'b0);
    px("g.grass712", 712, 700, 1'b0, 1'b0);

    // Speed 100 from a fresh offset, then clamp of 200
    do_reset();
    speed_in = 8'd100;
    frame_tick("s100.a");
    check("s100.a.100", 32'(offset_out), 32'd100);
    frame_tick("s100.b");
    check("s100.b.72", 32'(offset_out), 32'd72);
    frame_tick("s100.c");
    check("s100.c.44", 32'(offset_out), 32'd44);
    do_reset();
    speed_in = 8'd200;
    frame_tick("s200");
    check("s200.offset127", 32'(offset_out), 32'd127);
    check("s200.dist127", 32'(distance_out), 32'd127);

    // Distance saturation, then menu clears distance and holds offset
    speed_in = 8'd255;
    for (int i = 0; i < 520; i++) frame_tick($sformatf("sat.%0d", i));
    check("sat.ffff", 32'(distance_out), 32'hFFFF);
    mode_in = 1'b0;
    frame_tick("menu.clear");
    check("menu.dist0", 32'(distance_out), 32'd0);

    // Menu panel
    px("m.corner", 242, 119, 1'b0, 1'b0);
    px("m.panel", 300, 300, 1'b0, 1'b0);
    px("m.sky", 100, 100, 1'b0, 1'b0);
    px("m.grass", 100, 700, 1'b0, 1'b0);
    px("m.edge243", 243, 300, 1'b0, 1'b0);
    px("m.in244", 244, 300, 1'b0, 1'b0);
    px("m.edge781", 781, 300, 1'b0, 1'b0);
    px("m.out782", 782, 300, 1'b0, 1'b0);
    px("m.edge648", 300, 648, 1'b0, 1'b0);
    px("m.in646", 300, 646, 1'b0, 1'b0);

    // Mode change mid-frame is deferred to the next vblnk rise
    mode_in = 1'b1;
    speed_in = 8'd3;
    px("toggle.before", 300, 300, 1'b0, 1'b0);
    frame_tick("toggle.tick");
    px("toggle.after", 300, 300, 1'b0, 1'b0);

    // Randomized pixels and frames
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mode_in  = 1'($urandom_range(0, 1));
        speed_in = 8'($urandom_range(0, 255));
        frame_tick($sformatf("rnd.tick%0d", i));
      end else begin
        px($sformatf("rnd.%0d", i), int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)),
           ($urandom_range(0, 7) == 0), 1'b0);
      end
    end

    // Reset mid-frame with vblnk already high: no tick at release
    mode_in  = 1'b1;
    speed_in = 8'd5;
    drive(400, 460, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    step();
    check("midrst.rgb", 32'(rgb_out), 32'h000);
    check("midrst.offset", 32'(offset_out), 32'd0);
    check("midrst.dist", 32'(distance_out), 32'd0);
    check("midrst.hcount", 32'(out_if.hcount), 32'd0);
    rst = 1'b0;
    step();
    step();
    step();
    check("release.notick", 32'(offset_out), 32'(m_offset));
    check("release.nodist", 32'(distance_out), 32'(m_dist));
    frame_tick("release.firsttick");
    check("release.offset5", 32'(offset_out), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
